mic_frame_sequencer: RTL and testbench
======================================

# mic_frame_sequencer

Downstream stage of the PDM-to-PCM accumulator/FIFO array. It drains the per-microphone sample FIFOs round-robin and presents one byte at a time to the SPI slave. Each SPI transaction (ssel low) carries one framed snapshot to the RasPi: a sync byte, a sequence number, then one sample per microphone in mic order. It runs entirely in the system clock domain, on the FIFO read side.

## Interface
Parameters:
- NUM_MICS, 25, number of microphone channels and FIFOs.
- BIT_WIDTH, 8, sample width, legal range 1..8.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ssel  in  1  SPI slave select, asynchronous, active low.
- data_needed  in  1  spi_slave dataNeeded, asynchronous; rising edge means the current byte was taken and the next is required.
- data_to_send  out  8  byte presented to spi_slave dataToSend.
- fifo_rdreq  out  NUM_MICS  one-hot, one-cycle pop strobe per FIFO.
- fifo_rdempty  in  NUM_MICS  per-FIFO empty flag.
- fifo_q  in  NUM_MICS*BIT_WIDTH  show-ahead FIFO heads; mic k occupies bits [k*BIT_WIDTH +: BIT_WIDTH].
- frame_active  out  1  high from frame start until frame end or abort.
- frame_seq  out  8  sequence number of the next frame to send.
- underrun_count  out  16  saturating count of samples sent while their FIFO was empty.

## Operation
- ssel and data_needed each pass through a 2-FF synchronizer, then an edge detector on the synchronized value.
- States: IDLE, SYNC, SEQ, SAMPLE, CKSUM (macro only), DONE.
- Byte order: SYNC_BYTE, frame_seq, sample mic0 … mic NUM_MICS-1, optional checksum.
- **IDLE:** on an ssel falling edge:
  - data_to_send <= SYNC_BYTE
  - frame_active <= 1
  - mic index <= 0
  - go to SYNC.
- **SYNC:** on a data_needed rising edge, data_to_send <= frame_seq; go to SEQ.
- **SEQ, and SAMPLE with index k < NUM_MICS:** on a data_needed rising edge, load sample k.
  - If fifo_rdempty[k] = 0: data_to_send <= zero-extended fifo_q slice k, and pulse fifo_rdreq[k] for exactly one cycle.
  - If fifo_rdempty[k] = 1: data_to_send <= 8'h00, underrun_count += 1 (saturates at 16'hFFFF), no pop.
  - Increment the index. After the last mic, go to CKSUM if the macro is defined, otherwise DONE.
- **DONE:** each further data_needed edge loads 8'h00; no pops.
- **Frame completion:** the ssel rising edge in DONE completes the frame.
  - frame_seq += 1, wrapping 8'hFF -> 8'h00.
  - frame_active <= 0; go to IDLE.
- **Abort:** an ssel rising edge in any other non-IDLE state.
  - Go to IDLE and clear frame_active.
  - frame_seq is unchanged. Samples already popped stay consumed.
- **Simultaneous edges:** an ssel edge has priority over a data_needed edge in the same cycle. The data_needed edge is discarded.
- data_needed edges in IDLE are ignored.

## Timing
- Reset values:
  - data_to_send = 8'h00, fifo_rdreq = 0, frame_active = 0, frame_seq = 8'h00, underrun_count = 0, state = IDLE.
  - Synchronizer flops reset to 1 for ssel and 0 for data_needed.
- Edge detect occurs 2 clk after the pin transition; the edge pulse lasts 1 cycle.
- data_to_send and fifo_rdreq are registered. Both update on the clk edge after the cycle in which the edge pulse is high.
- At most one fifo_rdreq bit is high in any cycle. A pop never repeats without a new data_needed edge.
- fifo_q slice k is sampled in the same cycle rdreq[k] is asserted, so the show-ahead head is captured before the pop.
- Reset asserted mid-frame returns all outputs to their reset values immediately. No pop is issued during reset.

## Configuration
- MICFRAME_CHECKSUM_EN defined:
  - After the last sample, the next data_needed edge loads the XOR of frame_seq and all sample bytes as sent (underrun zeros included), then goes to DONE.
  - Frame length is NUM_MICS+3 bytes.
- MICFRAME_CHECKSUM_EN undefined: no CKSUM state or accumulator; frame length is NUM_MICS+2 bytes.

## Structure
- Package micframe_pkg holds:
  - the state enum
  - the SYNC_BYTE default
  - a MIC_IDX_W constant (clog2 of NUM_MICS, minimum 1)
  - the saturation limit for underrun_count.
- One sub-module, sync_edge: 2-FF synchronizer with a reset-value parameter, producing rise and fall pulses. It is instantiated twice.

## Test plan
- **Full frame, 3 mics, BIT_WIDTH 8:** FIFOs hold 8'h11/8'h22/8'h33; ssel low, then 4 data_needed edges.
  - Bytes A5, 00, 11, 22, 33; each rdreq pulses once.
  - On ssel high, frame_seq = 01.
- **Underrun:** FIFO 1 empty.
  - Sample byte 1 = 00, no rdreq[1], underrun_count = 1.
  - Other mics are popped normally.
- **Abort:** ssel rises after the byte for mic 0.
  - Only rdreq[0] has fired; frame_seq stays 00.
  - The next frame restarts at A5.
- **Priority:** ssel rising edge and data_needed edge synchronized in the same cycle → abort, no pop, data_to_send unchanged.
- **Wrap and saturation:**
  - 256 complete frames → frame_seq returns to 00.
  - underrun_count forced to FFFF plus one more underrun → stays FFFF.
- **Checksum (macro on):** samples 11, 22, 33 with seq 05 → last byte = 05^11^22^33 = 05.
  - Further data_needed edges return 00.

Source files
------------

// File: rtl/micframe_pkg.sv
// rtl/micframe_pkg.sv - shared types and constants for the mic frame sequencer
// Optional feature macro: MICFRAME_CHECKSUM_EN (adds the CKSUM state).
package micframe_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [15:0] UNDERRUN_MAX      = 16'hFFFF;
    localparam int          NUM_MICS_DEFAULT  = 25;

    // Index width for a mic counter; never narrower than one bit.
    function automatic int mic_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int MIC_IDX_W = mic_idx_w(NUM_MICS_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_SEQ    = 3'd2,
        ST_SAMPLE = 3'd3,
`ifdef MICFRAME_CHECKSUM_EN
        ST_CKSUM  = 3'd4,
`endif
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with rise/fall edge pulses
// Ports: clk, reset_n (async, active low), din (asynchronous level),
//        rise/fall (one-cycle pulses on the synchronized value).
// RESET_VAL sets the idle level the flops assume during reset so that
// leaving reset does not fabricate an edge.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/mic_frame_sequencer.sv
// rtl/mic_frame_sequencer.sv - drains per-mic FIFOs into framed SPI bytes
// Ports: clk, reset_n (async, active low); ssel, data_needed (async SPI-side
//        strobes); data_to_send (byte to spi_slave); fifo_rdreq/fifo_rdempty/
//        fifo_q (show-ahead FIFO read side); frame_active, frame_seq,
//        underrun_count (status).
// Optional feature macro: MICFRAME_CHECKSUM_EN appends an XOR checksum byte.
module mic_frame_sequencer
    import micframe_pkg::*;
#(
    parameter int         NUM_MICS  = 25,
    parameter int         BIT_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ssel,
    input  logic                          data_needed,
    output logic [7:0]                    data_to_send,
    output logic [NUM_MICS-1:0]           fifo_rdreq,
    input  logic [NUM_MICS-1:0]           fifo_rdempty,
    input  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q,
    output logic                          frame_active,
    output logic [7:0]                    frame_seq,
    output logic [15:0]                   underrun_count
);

    localparam int IDX_W = mic_idx_w(NUM_MICS);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             ssel_rise;
    logic             ssel_fall;
    logic             dn_rise;
    logic [7:0]       sample_byte;
    logic             sample_empty;
    logic             last_mic;
`ifdef MICFRAME_CHECKSUM_EN
    logic [7:0]       cksum;
`endif

    sync_edge #(.RESET_VAL(1'b1)) u_ssel_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ssel),
        .rise    (ssel_rise),
        .fall    (ssel_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_dn_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (data_needed),
        .rise    (dn_rise),
        .fall    ()
    );

    // Show-ahead head of the current mic, zero-extended to a byte; it is
    // captured in the same cycle its pop is issued.
    always_comb begin
        sample_byte                  = '0;
        sample_byte[BIT_WIDTH-1:0]   = fifo_q[idx*BIT_WIDTH +: BIT_WIDTH];
        sample_empty                 = fifo_rdempty[idx];
        last_mic                     = (idx == IDX_W'(NUM_MICS - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            data_to_send   <= 8'h00;
            fifo_rdreq     <= '0;
            frame_active   <= 1'b0;
            frame_seq      <= 8'h00;
            underrun_count <= 16'h0000;
`ifdef MICFRAME_CHECKSUM_EN
            cksum          <= 8'h00;
`endif
        end else begin
            fifo_rdreq <= '0;
            if (state == ST_IDLE) begin
                if (ssel_fall) begin
                    data_to_send <= SYNC_BYTE;
                    frame_active <= 1'b1;
                    idx          <= '0;
                    state        <= ST_SYNC;
                end
            end else if (ssel_rise) begin
                // ssel edge wins over a coincident data_needed edge; only a
                // frame that reached DONE advances the sequence number.
                if (state == ST_DONE) begin
                    frame_seq <= frame_seq + 8'd1;
                end
                frame_active <= 1'b0;
                state        <= ST_IDLE;
            end else if (dn_rise) begin
                case (state)
                    ST_SYNC: begin
                        data_to_send <= frame_seq;
`ifdef MICFRAME_CHECKSUM_EN
                        cksum        <= frame_seq;
`endif
                        state        <= ST_SEQ;
                    end
                    ST_SEQ, ST_SAMPLE: begin
                        if (!sample_empty) begin
                            data_to_send <= sample_byte;
                            fifo_rdreq   <= NUM_MICS'(1) << idx;
`ifdef MICFRAME_CHECKSUM_EN
                            cksum        <= cksum ^ sample_byte;
`endif
                        end else begin
                            data_to_send <= 8'h00;
                            if (underrun_count != UNDERRUN_MAX) begin
                                underrun_count <= underrun_count + 16'd1;
                            end
                        end
                        if (last_mic) begin
`ifdef MICFRAME_CHECKSUM_EN
                            state <= ST_CKSUM;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_SAMPLE;
                        end
                    end
`ifdef MICFRAME_CHECKSUM_EN
                    ST_CKSUM: begin
                        data_to_send <= cksum;
                        state        <= ST_DONE;
                    end
`endif
                    default: begin
                        data_to_send <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mic_frame_sequencer.sv
// tb/tb_mic_frame_sequencer.sv - directed self-checking bench for mic_frame_sequencer
module tb_mic_frame_sequencer;

    localparam int NM = 3;
    localparam int BW = 8;
`ifdef MICFRAME_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            ssel = 1'b1;
    logic            data_needed = 1'b0;
    logic [7:0]      data_to_send;
    logic [NM-1:0]   fifo_rdreq;
    logic [NM-1:0]   fifo_rdempty = '0;
    logic [NM*BW-1:0] fifo_q = {8'h33, 8'h22, 8'h11};
    logic            frame_active;
    logic [7:0]      frame_seq;
    logic [15:0]     underrun_count;

    int checks = 0;
    int failures = 0;
    int pop_cnt [NM];
    int multi_hot = 0;

    mic_frame_sequencer #(
        .NUM_MICS  (NM),
        .BIT_WIDTH (BW),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ssel           (ssel),
        .data_needed    (data_needed),
        .data_to_send   (data_to_send),
        .fifo_rdreq     (fifo_rdreq),
        .fifo_rdempty   (fifo_rdempty),
        .fifo_q         (fifo_q),
        .frame_active   (frame_active),
        .frame_seq      (frame_seq),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if ($countones(fifo_rdreq) > 1) multi_hot++;
        for (int k = 0; k < NM; k++) begin
            if (fifo_rdreq[k]) pop_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dn_edge();
        data_needed = 1'b1;
        wait_clk(4);
        data_needed = 1'b0;
        wait_clk(4);
    endtask

    task automatic clear_pops();
        for (int k = 0; k < NM; k++) pop_cnt[k] = 0;
    endtask

    task automatic check_pops(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_pop0"}, 16'(pop_cnt[0]), 16'(e0));
        check({tag, "_pop1"}, 16'(pop_cnt[1]), 16'(e1));
        check({tag, "_pop2"}, 16'(pop_cnt[2]), 16'(e2));
    endtask

    task automatic run_frame();
        ssel = 1'b0;
        wait_clk(4);
        repeat (NM + 1 + CK) dn_edge();
        ssel = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        clear_pops();
        // Reset state
        wait_clk(3);
        check("rst_data", 16'(data_to_send), 16'h00);
        check("rst_rdreq", 16'(fifo_rdreq), 16'h0);
        check("rst_active", 16'(frame_active), 16'h0);
        check("rst_seq", 16'(frame_seq), 16'h00);
        check("rst_underrun", underrun_count, 16'h0000);
        reset_n = 1'b1;
        wait_clk(2);

        // Full frame, all FIFOs holding data
        ssel = 1'b0;
        wait_clk(4);
        check("full_sync", 16'(data_to_send), 16'hA5);
        check("full_active", 16'(frame_active), 16'h1);
        dn_edge();
        check("full_seq", 16'(data_to_send), 16'h00);
        dn_edge();
        check("full_s0", 16'(data_to_send), 16'h11);
        dn_edge();
        check("full_s1", 16'(data_to_send), 16'h22);
        dn_edge();
        check("full_s2", 16'(data_to_send), 16'h33);
`ifdef MICFRAME_CHECKSUM_EN
        dn_edge();
        check("full_cksum", 16'(data_to_send), 16'h00);
`endif
        dn_edge();
        check("full_done", 16'(data_to_send), 16'h00);
        check_pops("full", 1, 1, 1);
        ssel = 1'b1;
        wait_clk(4);
        check("full_seq_after", 16'(frame_seq), 16'h01);
        check("full_inactive", 16'(frame_active), 16'h0);
        check("full_underrun", underrun_count, 16'h0000);

        // Underrun on mic 1
        clear_pops();
        fifo_rdempty = 3'b010;
        ssel = 1'b0;
        wait_clk(4);
        check("ur_sync", 16'(data_to_send), 16'hA5);
        dn_edge();
        check("ur_seq", 16'(data_to_send), 16'h01);
        dn_edge();
        check("ur_s0", 16'(data_to_send), 16'h11);
        dn_edge();
        check("ur_s1", 16'(data_to_send), 16'h00);
        dn_edge();
        check("ur_s2", 16'(data_to_send), 16'h33);
`ifdef MICFRAME_CHECKSUM_EN
        dn_edge();
        check("ur_cksum", 16'(data_to_send), 16'h23);
        dn_edge();
        check("ur_done", 16'(data_to_send), 16'h00);
`endif
        ssel = 1'b1;
        wait_clk(4);
        check_pops("ur", 1, 0, 1);
        check("ur_count", underrun_count, 16'h0001);
        check("ur_seq_after", 16'(frame_seq), 16'h02);
        fifo_rdempty = 3'b000;

        // Abort after mic 0
        clear_pops();
        ssel = 1'b0;
        wait_clk(4);
        dn_edge();
        dn_edge();
        check("ab_s0", 16'(data_to_send), 16'h11);
        ssel = 1'b1;
        wait_clk(4);
        check_pops("ab", 1, 0, 0);
        check("ab_seq", 16'(frame_seq), 16'h02);
        check("ab_inactive", 16'(frame_active), 16'h0);
        ssel = 1'b0;
        wait_clk(4);
        check("ab_restart", 16'(data_to_send), 16'hA5);

        // Priority: ssel rise and data_needed rise synchronized together
        dn_edge();
        check("pri_seq_byte", 16'(data_to_send), 16'h02);
        clear_pops();
        ssel = 1'b1;
        data_needed = 1'b1;
        wait_clk(4);
        data_needed = 1'b0;
        wait_clk(4);
        check("pri_data", 16'(data_to_send), 16'h02);
        check_pops("pri", 0, 0, 0);
        check("pri_inactive", 16'(frame_active), 16'h0);
        check("pri_seq", 16'(frame_seq), 16'h02);

        // data_needed in IDLE is ignored
        dn_edge();
        check("idle_dn", 16'(data_to_send), 16'h02);

        // Sequence wrap: 254 more frames take 02 through FF back to 00
        repeat (254) run_frame();
        check("wrap_seq", 16'(frame_seq), 16'h00);
        check("wrap_underrun", underrun_count, 16'h0001);

        // Saturation of underrun_count
        force dut.underrun_count = 16'hFFFF;
        wait_clk(1);
        release dut.underrun_count;
        wait_clk(1);
        fifo_rdempty = 3'b111;
        clear_pops();
        run_frame();
        check("sat_count", underrun_count, 16'hFFFF);
        check_pops("sat", 0, 0, 0);
        check("sat_seq", 16'(frame_seq), 16'h01);
        fifo_rdempty = 3'b000;

        // Reset during an active pop
        ssel = 1'b0;
        wait_clk(4);
        dn_edge();
        data_needed = 1'b1;
        wait_clk(3);
        check("mid_pop", 16'(fifo_rdreq), 16'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rdreq", 16'(fifo_rdreq), 16'h0);
        check("mid_rst_data", 16'(data_to_send), 16'h00);
        check("mid_rst_active", 16'(frame_active), 16'h0);
        check("mid_rst_seq", 16'(frame_seq), 16'h00);
        check("mid_rst_underrun", underrun_count, 16'h0000);
        ssel = 1'b1;
        data_needed = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        check("post_rst_data", 16'(data_to_send), 16'h00);

        check("onehot_rdreq", 16'(multi_hot), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
